// File: rtl/mm_pkg.sv
// Shared types and constants for the matrix-multiplier issue path.
// Optional feature macro: MM_ISSUE_SATURATE_EN (saturating accumulation).
package mm_pkg;

  localparam int unsigned MM_DATA_W = 32;

  // Signed saturation limits for the dot-product accumulator
  localparam logic [MM_DATA_W-1:0] MM_SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [MM_DATA_W-1:0] MM_SAT_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_REPORT = 3'd5
  } mm_issue_state_t;

endpackage

// File: rtl/mm_acc.sv
// Signed dot-product accumulator with clear and add-enable.
// MM_ISSUE_SATURATE_EN defined: clamps to signed limits and keeps a sticky
// overflow flag; undefined: wraps modulo 2^32 and never flags overflow.
module mm_acc
  import mm_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 add_en,
  input  logic [MM_DATA_W-1:0] add_val,
  output logic [MM_DATA_W-1:0] sum,
  output logic                 ovf
);

`ifdef MM_ISSUE_SATURATE_EN
  logic [MM_DATA_W:0] wide;

  // Sign-extended sum; the top two bits disagree exactly on signed overflow
  assign wide = {sum[MM_DATA_W-1], sum} + {add_val[MM_DATA_W-1], add_val};

  // Saturating accumulate with sticky overflow
  always_ff @(posedge clk) begin
    if (!reset) begin
      sum <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      sum <= '0;
      ovf <= 1'b0;
    end else if (add_en) begin
      if (wide[MM_DATA_W] != wide[MM_DATA_W-1]) begin
        sum <= wide[MM_DATA_W] ? MM_SAT_MIN : MM_SAT_MAX;
        ovf <= 1'b1;
      end else begin
        sum <= wide[MM_DATA_W-1:0];
      end
    end
  end
`else
  // Wrapping accumulate; overflow is never reported
  always_ff @(posedge clk) begin
    if (!reset) begin
      sum <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      sum <= '0;
      ovf <= 1'b0;
    end else if (add_en) begin
      sum <= sum + add_val;
      ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/mm_issue_ctrl.sv
// Initiator-side issue controller for the matrix multiplier: takes a job
// length, streams operand pairs into the multiplier one at a time and returns
// the accumulated dot product. Saturation is enabled by MM_ISSUE_SATURATE_EN.
module mm_issue_ctrl
  import mm_pkg::*;
#(
  parameter  int unsigned MAX_LEN = 16,
  parameter  int unsigned TIMEOUT = 15,
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [MM_DATA_W-1:0] op_a,
  input  logic [MM_DATA_W-1:0] op_b,
  output logic                 mul_start,
  output logic [MM_DATA_W-1:0] mul_a,
  output logic [MM_DATA_W-1:0] mul_b,
  input  logic                 mul_done,
  input  logic [MM_DATA_W-1:0] mul_result,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [MM_DATA_W-1:0] res_data,
  output logic [LEN_W-1:0]     res_count,
  output logic                 res_error,
  output logic                 busy
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  mm_issue_state_t  state, state_n;
  logic [LEN_W-1:0] len, count, drain_left, drain_left_n;
  logic [TMR_W-1:0] timer;
  logic             error;
  logic             acc_ovf;

  logic accept_cmd, accept_op, done_hit, timed_out, drain_take;

  // Next-state decode and per-cycle event strobes
  always_comb begin
    state_n      = state;
    accept_cmd   = 1'b0;
    accept_op    = 1'b0;
    done_hit     = 1'b0;
    timed_out    = 1'b0;
    drain_take   = 1'b0;
    drain_left_n = drain_left;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept_cmd = 1'b1;
          if (cmd_len == '0 || cmd_len > LEN_W'(MAX_LEN)) state_n = ST_REPORT;
          else                                           state_n = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (op_valid) begin
          accept_op = 1'b1;
          state_n   = ST_ISSUE;
        end
      end
      ST_ISSUE: state_n = ST_WAIT;
      ST_WAIT: begin
        if (mul_done) begin
          done_hit = 1'b1;
          state_n  = (LEN_W'(count + LEN_W'(1)) == len) ? ST_REPORT : ST_FETCH;
        end else if (timer == TMR_W'(TIMEOUT)) begin
          // The timed-out pair is already consumed, so one fewer to discard
          timed_out    = 1'b1;
          drain_left_n = len - count - LEN_W'(1);
          state_n      = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_left == '0) begin
          state_n = ST_REPORT;
        end else if (op_valid) begin
          drain_take   = 1'b1;
          drain_left_n = drain_left - LEN_W'(1);
          if (drain_left == LEN_W'(1)) state_n = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (res_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, job bookkeeping and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      len        <= '0;
      count      <= '0;
      drain_left <= '0;
      timer      <= '0;
      error      <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      cmd_ready  <= 1'b1;
      op_ready   <= 1'b0;
      mul_start  <= 1'b0;
      res_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      drain_left <= drain_left_n;
      cmd_ready  <= (state_n == ST_IDLE);
      busy       <= (state_n != ST_IDLE);
      res_valid  <= (state_n == ST_REPORT);
      mul_start  <= (state_n == ST_ISSUE);
      op_ready   <= (state_n == ST_FETCH) ||
                    ((state_n == ST_DRAIN) && (drain_left_n != '0));

      if (accept_cmd) begin
        len   <= cmd_len;
        count <= '0;
        error <= (cmd_len > LEN_W'(MAX_LEN));
      end
      if (accept_op) begin
        mul_a <= op_a;
        mul_b <= op_b;
      end
      if (state == ST_ISSUE) timer <= '0;
      else if (state == ST_WAIT && !done_hit && !timed_out) timer <= timer + TMR_W'(1);
      if (done_hit)  count <= count + LEN_W'(1);
      if (timed_out) error <= 1'b1;
    end
  end

  mm_acc u_acc (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept_cmd),
    .add_en  (done_hit),
    .add_val (mul_result),
    .sum     (res_data),
    .ovf     (acc_ovf)
  );

  assign res_count = count;
  assign res_error = error | acc_ovf;

endmodule
